// File: rtl/booth_radix4_seq_mul.sv
// Sequential 8x8 signed radix-4 Booth multiplier: one Booth digit per cycle through booth_radix4_enc.
// Optional EARLY_TERM_EN: leave RUN as soon as the remaining multiplier digits are all zero.

module booth_radix4_enc (
    input  logic [2:0] mul_i,
    input  logic [7:0] data_i,
    output logic [8:0] res_o,
    output logic       sign_o,
    output logic       ext_o
);
    logic       sel_one;
    logic       sel_two;
    logic       neg;
    logic [8:0] d_one;
    logic [8:0] d_two;

    assign sel_one = mul_i[1] ^ mul_i[0];
    assign sel_two = (mul_i == 3'b011) || (mul_i == 3'b100);
    // Digit 3'b111 is -0: treat as plain zero so no stray +1 is produced.
    assign neg     = mul_i[2] & ~(mul_i[1] & mul_i[0]);
    assign d_one   = {data_i[7], data_i};
    assign d_two   = {data_i, 1'b0};

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_res_bit
            assign res_o[gi] = ((sel_one & d_one[gi]) | (sel_two & d_two[gi])) ^ neg;
        end
    endgenerate

    assign sign_o = neg;
    assign ext_o  = res_o[8];
endmodule

module booth_radix4_seq_mul #(
    parameter int DATA_W = 8,
    parameter int PROD_W = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] mul_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [PROD_W-1:0] prod_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_reg, state_next;
    logic [PROD_W-1:0] acc_reg, acc_next;
    logic [1:0]        step_reg, step_next;
    logic [DATA_W-1:0] mul_reg, mul_next;
    logic [DATA_W-1:0] data_reg, data_next;

    logic [DATA_W:0]   mul_ext;
    logic [2:0]        shamt;
    logic [2:0]        digit;
    logic [8:0]        enc_res;
    logic              enc_sign;
    logic              enc_ext;
    logic [PROD_W-1:0] pp;
    logic              last_step;

    // mul[-1] = 0 is appended below bit 0 so digit s is simply mul_ext[2s +: 3].
    assign mul_ext = {mul_reg, 1'b0};
    assign shamt   = {step_reg, 1'b0};
    assign digit   = mul_ext[shamt +: 3];

    booth_radix4_enc u_enc (
        .mul_i  (digit),
        .data_i (data_reg),
        .res_o  (enc_res),
        .sign_o (enc_sign),
        .ext_o  (enc_ext)
    );

    // Sign-extend and add the +1 before shifting so the -2 * -128 digit stays exact.
    assign pp = {{7{enc_ext}}, enc_res} + {{(PROD_W-1){1'b0}}, enc_sign};

`ifdef EARLY_TERM_EN
    assign last_step = (step_reg == 2'd3) ||
                       ((mul_reg >> (shamt + 3'd1)) == {DATA_W{1'b0}});
`else
    assign last_step = (step_reg == 2'd3);
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            step_reg  <= '0;
            mul_reg   <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            step_reg  <= step_next;
            mul_reg   <= mul_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        step_next   = step_reg;
        mul_next    = mul_reg;
        data_next   = data_reg;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        prod_o      = '0;
        case (state_reg)
            IDLE: begin
                in_ready_o = nreset;
                if (in_valid_i && nreset) begin
                    mul_next   = mul_i;
                    data_next  = data_i;
                    acc_next   = '0;
                    step_next  = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                acc_next  = acc_reg + (pp << shamt);
                step_next = step_reg + 2'd1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                prod_o      = acc_reg;
                if (out_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_booth_radix4_seq_mul.sv
// Directed bench for booth_radix4_seq_mul: products, latency, backpressure and mid-op reset.
// Define EARLY_TERM_EN here as well when the DUT is built with it.

module tb_booth_radix4_seq_mul;
    logic        clk;
    logic        nreset;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [7:0]  mul_i;
    logic [7:0]  data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] prod_o;

    int n_vec = 0;
    int n_err = 0;

    booth_radix4_seq_mul dut (
        .clk         (clk),
        .nreset      (nreset),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .mul_i       (mul_i),
        .data_i      (data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .prod_o      (prod_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Accumulate edges until out_valid: the whole digit count, or fewer when early exit is built in.
    function automatic int exp_lat(input logic [7:0] m);
`ifdef EARLY_TERM_EN
        logic [7:0] rest;
        for (int s = 0; s < 3; s++) begin
            rest = m >> (2 * s + 1);
            if (rest == 8'd0) return s + 1;
        end
        return 4;
`else
        return (m == m) ? 4 : 4;
`endif
    endfunction

    task automatic run_op(input logic [7:0] m, input logic [7:0] d, input logic [15:0] expp);
        int lat;
        int w;
        w = 0;
        while (!in_ready_o && w < 20) begin
            tick();
            w++;
        end
        check("in_ready_before_accept", in_ready_o, 1);
        mul_i      = m;
        data_i     = d;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        check("in_ready_during_run", in_ready_o, 0);
        lat = 0;
        while (!out_valid_o && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", lat, exp_lat(m));
        check("prod", prod_o, expp);
        $display("op mul=%02h data=%02h prod=%04h expected=%04h latency=%0d", m, d, prod_o, expp, lat);
        out_ready_i = 1'b1;
        tick();
        check("out_valid_after_hs", out_valid_o, 0);
        check("in_ready_after_hs", in_ready_o, 1);
    endtask

    initial begin
        logic [15:0] held;
        int w;
        nreset      = 1'b0;
        in_valid_i  = 1'b0;
        mul_i       = 8'h00;
        data_i      = 8'h00;
        out_ready_i = 1'b1;

        // Reset state
        #12;
        check("rst_in_ready", in_ready_o, 0);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_prod", prod_o, 16'h0000);
        @(negedge clk);
        nreset = 1'b1;
        tick();
        check("in_ready_after_rst", in_ready_o, 1);

        // Directed products
        run_op(8'h07, 8'hFD, 16'hFFEB);
        run_op(8'h80, 8'h80, 16'h4000);
        run_op(8'h7F, 8'h7F, 16'h3F01);
        run_op(8'h80, 8'h7F, 16'hC080);
        run_op(8'hFF, 8'h03, 16'hFFFD);
        run_op(8'h03, 8'h80, 16'hFE80);
        run_op(8'h00, 8'h55, 16'h0000);
        run_op(8'h01, 8'h05, 16'h0005);

        // Backpressure: hold DONE for 10 cycles
        out_ready_i = 1'b0;
        mul_i       = 8'h7F;
        data_i      = 8'h80;
        in_valid_i  = 1'b1;
        tick();
        in_valid_i = 1'b0;
        w = 0;
        while (!out_valid_o && w < 20) begin
            tick();
            w++;
        end
        check("bp_out_valid", out_valid_o, 1);
        check("bp_prod", prod_o, 16'hC080);
        held = prod_o;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_prod_stable", prod_o, held);
            check("bp_in_ready_low", in_ready_o, 0);
            check("bp_valid_held", out_valid_o, 1);
        end
        $display("backpressure prod=%04h held 10 cycles", prod_o);
        out_ready_i = 1'b1;
        tick();
        check("bp_release_valid", out_valid_o, 0);
        check("bp_release_ready", in_ready_o, 1);

        // Reset in the middle of RUN (after two accumulate edges)
        mul_i      = 8'h7F;
        data_i     = 8'h7F;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        tick();
        tick();
        #2;
        nreset = 1'b0;
        #1;
        check("midrst_out_valid", out_valid_o, 0);
        check("midrst_in_ready", in_ready_o, 0);
        tick();
        nreset = 1'b1;
        #1;
        check("midrst_release_ready", in_ready_o, 1);
        check("midrst_release_valid", out_valid_o, 0);
        tick();
        check("midrst_no_product", out_valid_o, 0);
        $display("mid-operation reset applied and released");
        run_op(8'h05, 8'h05, 16'h0019);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
